// File: rtl/bcd_angle_entry_if.sv
// bcd_angle_entry_if
//   Bundles the keypad strobes and the entry/commit outputs of the BCD
//   angle entry block.
//   master : keypad/controller side (drives strobes, observes results)
//   slave  : bcd_angle_entry side
//   Signals:
//     digit_in   [3:0]        keypad digit code, qualified by digit_stb
//     digit_stb               append digit_in as new least-significant digit
//     bksp                    delete least-significant entered digit
//     enter                   validate and commit the entry
//     clr                     discard entry and any error
//     entry_val  [4*NDIG-1:0] in-progress value, right-aligned, zero-filled
//     digit_cnt  [1:0]        digits currently entered
//     bcd_out    [4*NDIG-1:0] last committed value
//     bcd_valid               one-cycle pulse when bcd_out updates
//     err                     high while in the error state
//     err_code   [1:0]        00 none, 01 non-decimal digit, 10 out of range
interface bcd_angle_entry_if #(
  parameter int NDIG = 3
);
  logic [3:0]        digit_in;
  logic              digit_stb;
  logic              bksp;
  logic              enter;
  logic              clr;
  logic [4*NDIG-1:0] entry_val;
  logic [1:0]        digit_cnt;
  logic [4*NDIG-1:0] bcd_out;
  logic              bcd_valid;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output digit_in, digit_stb, bksp, enter, clr,
    input  entry_val, digit_cnt, bcd_out, bcd_valid, err, err_code
  );

  modport slave (
    input  digit_in, digit_stb, bksp, enter, clr,
    output entry_val, digit_cnt, bcd_out, bcd_valid, err, err_code
  );
endinterface

// File: rtl/bcd_angle_entry.sv
// bcd_angle_entry
//   Builds a packed NDIG-digit BCD angle from keypad strobes, one digit at a
//   time, validates each digit, range-checks the finished value against
//   MAX_BCD and commits it with a one-cycle bcd_valid pulse.
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  asynchronous active-high reset
//     bus    bcd_angle_entry_if.slave (strobes in, entry/commit/error out)
//   Strobe priority: clr > enter > bksp > digit_stb; only the winner acts.
module bcd_angle_entry #(
  parameter int                NDIG    = 3,
  parameter logic [4*NDIG-1:0] MAX_BCD = 'h360
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_angle_entry_if.slave        bus
);

  localparam int         W        = 4 * NDIG;
  localparam logic [1:0] NDIG_CNT = 2'(NDIG);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   entry_q;
  logic [1:0]     cnt_q;
  logic [W-1:0]   bcd_out_q;
  logic           valid_q;
  logic           err_q;
  logic [1:0]     err_code_q;

  logic           digit_ok;
  assign digit_ok = (bus.digit_in <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      entry_q    <= '0;
      cnt_q      <= 2'd0;
      bcd_out_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      // Commit pulse lasts exactly one cycle; after a commit the state is
      // HOLD, where enter is ignored, so two back-to-back pulses cannot occur.
      valid_q <= 1'b0;

      if (bus.clr) begin
        state_q    <= S_EMPTY;
        entry_q    <= '0;
        cnt_q      <= 2'd0;
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
      end else if (state_q != S_ERR) begin
        if (bus.enter) begin
          if (state_q == S_ENTRY) begin
            // Packed BCD orders the same as unsigned binary, so a plain
            // compare is the range check.
            if (entry_q <= MAX_BCD) begin
              bcd_out_q <= entry_q;
              valid_q   <= 1'b1;
              state_q   <= S_HOLD;
            end else begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end
          end
        end else if (bus.bksp) begin
          if (state_q == S_ENTRY) begin
            entry_q <= entry_q >> 4;
            cnt_q   <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              state_q <= S_EMPTY;
            end
          end
        end else if (bus.digit_stb) begin
          // The non-decimal check wins even when the entry is already full.
          if (!digit_ok) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
          end else if (state_q == S_HOLD) begin
            // First digit after a commit starts a fresh entry.
            entry_q <= {{(W-4){1'b0}}, bus.digit_in};
            cnt_q   <= 2'd1;
            state_q <= S_ENTRY;
          end else if (cnt_q < NDIG_CNT) begin
            entry_q <= {entry_q[W-5:0], bus.digit_in};
            cnt_q   <= cnt_q + 2'd1;
            state_q <= S_ENTRY;
          end
        end
      end
    end
  end

  assign bus.entry_val = entry_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.bcd_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_bcd_angle_entry.sv
module tb_bcd_angle_entry;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bcd_angle_entry_if #(.NDIG(3)) bus ();

  bcd_angle_entry #(.NDIG(3), .MAX_BCD(12'h360)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  // Apply one strobe combination for a single clock, then sample #1 after the edge.
  task automatic strobe(input logic [3:0] d, input logic ds, input logic bk,
                        input logic en, input logic cl);
    @(negedge clk);
    bus.digit_in  = d;
    bus.digit_stb = ds;
    bus.bksp      = bk;
    bus.enter     = en;
    bus.clr       = cl;
    @(posedge clk);
    #1;
    bus.digit_stb = 1'b0;
    bus.bksp      = 1'b0;
    bus.enter     = 1'b0;
    bus.clr       = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);
    strobe(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.digit_in  = 4'd0;
    bus.digit_stb = 1'b0;
    bus.bksp      = 1'b0;
    bus.enter     = 1'b0;
    bus.clr       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_entry", 32'(bus.entry_val), 32'h0);
    check("rst_cnt",   32'(bus.digit_cnt), 32'd0);
    check("rst_bcd",   32'(bus.bcd_out),   32'h0);
    check("rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    check("rst_code",  32'(bus.err_code),  32'd0);

    // 1,2,3 enter
    dig(4'd1);
    check("t1_d1", 32'(bus.entry_val), 32'h001);
    dig(4'd2);
    dig(4'd3);
    check("t1_entry", 32'(bus.entry_val), 32'h123);
    check("t1_cnt",   32'(bus.digit_cnt), 32'd3);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_bcd",   32'(bus.bcd_out),   32'h123);
    check("t1_valid", 32'(bus.bcd_valid), 32'd1);
    idle();
    check("t1_valid_off", 32'(bus.bcd_valid), 32'd0);
    check("t1_hold_entry", 32'(bus.entry_val), 32'h123);
    check("t1_hold_cnt",   32'(bus.digit_cnt), 32'd3);

    // 3,6,0 from HOLD: fresh entry, boundary accepted
    dig(4'd3);
    check("t2_fresh",     32'(bus.entry_val), 32'h003);
    check("t2_fresh_cnt", 32'(bus.digit_cnt), 32'd1);
    dig(4'd6);
    dig(4'd0);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_bcd",   32'(bus.bcd_out),   32'h360);
    check("t2_valid", 32'(bus.bcd_valid), 32'd1);
    strobe(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_clr_entry", 32'(bus.entry_val), 32'h0);
    check("t2_clr_cnt",   32'(bus.digit_cnt), 32'd0);
    check("t2_clr_bcd",   32'(bus.bcd_out),   32'h360);
    dig(4'd3);
    dig(4'd6);
    dig(4'd1);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_range_err",   32'(bus.err),       32'd1);
    check("t2_range_code",  32'(bus.err_code),  32'h2);
    check("t2_range_bcd",   32'(bus.bcd_out),   32'h360);
    check("t2_range_valid", 32'(bus.bcd_valid), 32'd0);
    strobe(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_clr_err", 32'(bus.err), 32'd0);

    // 4,5,bksp,7 enter
    dig(4'd4);
    dig(4'd5);
    check("t3_45", 32'(bus.entry_val), 32'h045);
    strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_bksp",     32'(bus.entry_val), 32'h004);
    check("t3_bksp_cnt", 32'(bus.digit_cnt), 32'd1);
    dig(4'd7);
    check("t3_47", 32'(bus.entry_val), 32'h047);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_bcd",   32'(bus.bcd_out),   32'h047);
    check("t3_valid", 32'(bus.bcd_valid), 32'd1);
    // 9,9,9 then extra 8 ignored
    dig(4'd9);
    dig(4'd9);
    dig(4'd9);
    dig(4'd8);
    check("t3_full_entry", 32'(bus.entry_val), 32'h999);
    check("t3_full_cnt",   32'(bus.digit_cnt), 32'd3);
    check("t3_full_err",   32'(bus.err),       32'd0);

    // Non-decimal digit -> ERR, everything but clr ignored
    dig(4'hB);
    check("t4_err",   32'(bus.err),       32'd1);
    check("t4_code",  32'(bus.err_code),  32'h1);
    check("t4_entry", 32'(bus.entry_val), 32'h999);
    strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_bksp_ign", 32'(bus.entry_val), 32'h999);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_enter_ign", 32'(bus.bcd_valid), 32'd0);
    check("t4_enter_bcd", 32'(bus.bcd_out),   32'h047);
    strobe(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_clr_err",   32'(bus.err),       32'd0);
    check("t4_clr_code",  32'(bus.err_code),  32'h0);
    check("t4_clr_cnt",   32'(bus.digit_cnt), 32'd0);
    check("t4_clr_entry", 32'(bus.entry_val), 32'h0);

    // Backspace to empty, then enter ignored
    dig(4'd5);
    strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_bk_empty", 32'(bus.digit_cnt), 32'd0);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_empty_enter", 32'(bus.bcd_valid), 32'd0);

    // enter+digit same cycle: commit, digit dropped
    dig(4'd1);
    dig(4'd2);
    strobe(4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_bcd",   32'(bus.bcd_out),   32'h012);
    check("t5_valid", 32'(bus.bcd_valid), 32'd1);
    check("t5_entry", 32'(bus.entry_val), 32'h012);
    dig(4'd7);
    strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_clr_enter_cnt",   32'(bus.digit_cnt), 32'd0);
    check("t5_clr_enter_valid", 32'(bus.bcd_valid), 32'd0);
    check("t5_clr_enter_bcd",   32'(bus.bcd_out),   32'h012);

    // Async reset mid-entry
    dig(4'd4);
    dig(4'd2);
    check("t6_pre", 32'(bus.entry_val), 32'h042);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_entry", 32'(bus.entry_val), 32'h0);
    check("t6_rst_cnt",   32'(bus.digit_cnt), 32'd0);
    check("t6_rst_bcd",   32'(bus.bcd_out),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    dig(4'd5);
    check("t6_entry", 32'(bus.entry_val), 32'h005);
    check("t6_cnt",   32'(bus.digit_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_angle_entry.md
Name: bcd_angle_entry

Overview:
- Sequential digit-entry front end that builds a packed 3-digit BCD angle from keypad strobes, one digit at a time.
- Validates each digit and range-checks the completed value against a programmable limit.
- Commits the value with a one-cycle valid pulse.
- Sits directly upstream of the BCD-to-binary converter; bcd_out feeds that block's 12-bit BCD input, which in turn feeds the CORDIC angle path.

Parameters:
- NDIG, 3, number of BCD digits; value width is 4*NDIG.
- MAX_BCD, 12'h360, largest accepted value, packed BCD, inclusive.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- digit_in  input  4  keypad digit code, sampled only when digit_stb=1
- digit_stb  input  1  one-cycle strobe: append digit_in as new least-significant digit
- bksp  input  1  one-cycle strobe: delete least-significant entered digit
- enter  input  1  one-cycle strobe: validate and commit entry
- clr  input  1  one-cycle strobe: discard entry, leave error, return to EMPTY
- entry_val  output  4*NDIG  in-progress BCD value for display, right-aligned, zero-filled
- digit_cnt  output  2  digits currently entered (0..NDIG)
- bcd_out  output  4*NDIG  last committed BCD value, stable between commits
- bcd_valid  output  1  one-cycle pulse, asserted the cycle bcd_out updates
- err  output  1  high while in ERR state
- err_code  output  2  00 none, 01 non-decimal digit, 10 out of range (> MAX_BCD)

Behaviour:
- Reset (async, any state): state EMPTY. entry_val=0, digit_cnt=0, bcd_out=0, bcd_valid=0, err=0, err_code=00. Reset mid-entry discards the partial value.
- States: EMPTY (cnt=0), ENTRY (1..NDIG digits), HOLD (value just committed), ERR.
- Strobe priority when several are high in the same cycle: clr > enter > bksp > digit_stb. Only the highest-priority strobe acts; the others are dropped.
- Digit append, digit_in <= 9, cnt < NDIG:
  - entry_val <= {entry_val[4*NDIG-5:0], digit_in}; cnt+1; state ENTRY.
  - Visible the cycle after the strobe.
- Digit with cnt == NDIG: ignored. No change, no error.
- Digit with digit_in > 9, in any state except ERR: state ERR, err_code=01. entry_val unchanged.
- Backspace in ENTRY: entry_val <= entry_val >> 4; cnt-1. When cnt reaches 0, state returns to EMPTY.
- Backspace in EMPTY or HOLD: ignored.
- Enter in EMPTY or HOLD: ignored, no pulse.
- Enter in ENTRY:
  - entry_val <= MAX_BCD (packed-BCD compare, equal to unsigned compare): bcd_out <= entry_val and bcd_valid=1 on the next cycle only; state HOLD.
  - entry_val > MAX_BCD: state ERR, err_code=10, bcd_out unchanged, no pulse.
- HOLD:
  - entry_val and digit_cnt keep showing the committed digits.
  - A valid digit strobe starts a fresh entry: entry_val <= {0.., digit_in}, cnt=1, state ENTRY.
- ERR:
  - err=1. All strobes except clr are ignored.
  - clr -> EMPTY, entry_val=0, cnt=0, err=0, err_code=00.
  - bcd_out is retained through ERR and clr.
- clr in any state -> EMPTY with the same clears. bcd_out is not affected.
- bcd_valid is never high for two consecutive cycles.
- Latency:
  - Every strobe-to-output effect is one clock.
  - bcd_out updates on the same edge bcd_valid rises.
- Purely synchronous apart from reset. Strobes are assumed already debounced and single-cycle; a strobe held high for k cycles acts k times.

Test Plan:
- Reset then digits 1,2,3 then enter -> entry_val 12'h123 after the third digit, digit_cnt 3; bcd_out 12'h123 with a single bcd_valid pulse one cycle after enter.
- Digits 3,6,0, enter -> commit 12'h360 (boundary accepted). Then clr and digits 3,6,1, enter -> err=1, err_code=10, bcd_out still 12'h360, no pulse.
- Digits 4,5, bksp, 7, enter -> entry_val 12'h045 then 12'h004 then 12'h047; bcd_out 12'h047. Digits 9,9,9 then extra 8 -> extra digit ignored, entry_val 12'h999.
- digit_in 4'hB strobed in ENTRY -> err_code=01. Subsequent digits, enter and bksp are ignored. clr -> err=0, digit_cnt 0, entry_val 0.
- Same-cycle enter+digit_stb on entry 12'h012 -> commit 12'h012, digit dropped. Same-cycle clr+enter -> EMPTY, no pulse.
- Assert reset asynchronously (between edges) mid-entry with 2 digits entered -> all outputs 0 immediately. After release, digit 5 -> entry_val 12'h005, digit_cnt 1.
